// File: rtl/mips_muldiv_seq.sv
// Multi-cycle MULTU/DIVU sequencer owning the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide, one iteration per clock.
module mips_muldiv_seq #(
    parameter int         WIDTH    = 32,
    parameter logic [3:0] OP_MULTU = 4'd3,
    parameter logic [3:0] OP_DIVU  = 4'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       AluOP,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   mul_p;
    logic [WIDTH-1:0] mul_q;
    logic [WIDTH:0]   div_r;
    logic [WIDTH:0]   div_t;
    logic [WIDTH:0]   div_acc;
    logic [WIDTH-1:0] div_q;
    logic             last;
    logic             launch;

    always_comb begin
        // acc_q holds P during multiply and R during divide
        mul_sum = acc_q + (q_q[0] ? {1'b0, y_q} : {(WIDTH+1){1'b0}});
        mul_p   = {1'b0, mul_sum[WIDTH:1]};
        mul_q   = {mul_sum[0], q_q[WIDTH-1:1]};
        div_r   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        div_t   = div_r - {1'b0, y_q};
        div_acc = div_t[WIDTH] ? div_r : div_t;
        div_q   = {q_q[WIDTH-2:0], ~div_t[WIDTH]};
        last    = (cnt_q == CW'(WIDTH-1));
        launch  = start && ((AluOP == OP_MULTU) || (AluOP == OP_DIVU));

        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        q_d     = q_q;
        y_d     = y_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    acc_d   = '0;
                    q_d     = X;
                    y_d     = Y;
                    cnt_d   = '0;
                    state_d = (AluOP == OP_MULTU) ? S_MUL : S_DIV;
                end else begin
                    if (mthi_we) hi_d = wdata;
                    if (mtlo_we) lo_d = wdata;
                end
            end
            S_MUL: begin
                acc_d = mul_p;
                q_d   = mul_q;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    hi_d    = mul_p[WIDTH-1:0];
                    lo_d    = mul_q;
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = div_acc;
                q_d   = div_q;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    hi_d    = div_acc[WIDTH-1:0];
                    lo_d    = div_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (mthi_we) hi_d = wdata;
                if (mtlo_we) lo_d = wdata;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            y_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            y_q     <= y_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == S_MUL) || (state_q == S_DIV);
    assign done = (state_q == S_DONE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Directed self-checking bench for mips_muldiv_seq: latency, results, HI/LO writes, reset.
module tb_mips_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  AluOP;
    logic [31:0] X, Y;
    logic        mthi_we, mtlo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    mips_muldiv_seq dut (
        .clk(clk), .rst(rst), .start(start), .AluOP(AluOP), .X(X), .Y(Y),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
        .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns just after the accepting edge.
    task automatic launch(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic hwe, input logic [31:0] wd);
        start = 1'b1; AluOP = op; X = x; Y = y; mthi_we = hwe; wdata = wd;
        tick();
        start = 1'b0; mthi_we = 1'b0; AluOP = 4'd0;
    endtask

    // inj: 0 none, 1 stray DIVU start, 2 mthi write while busy
    task automatic wait_done(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                             input int inj, input int inj_cyc);
        int c = 1;
        int bc = 0;
        int extra = 0;
        logic [31:0] hi_before = HI;
        while (!done && c < 100) begin
            if (busy) bc++;
            if (c == inj_cyc && inj == 1) begin
                start = 1'b1; AluOP = 4'd4; X = 32'd9; Y = 32'd2;
            end else if (c == inj_cyc && inj == 2) begin
                mthi_we = 1'b1; wdata = 32'hCAFEF00D;
            end else if (c == inj_cyc + 1 && inj == 2) begin
                mthi_we = 1'b0;
                check({tag, "_hi_hold"}, {32'd0, HI}, {32'd0, hi_before});
            end else begin
                start = 1'b0; mthi_we = 1'b0;
            end
            tick();
            c++;
        end
        start = 1'b0; mthi_we = 1'b0;
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_busy_cycles"}, 64'(bc), 64'd32);
        check({tag, "_latency"}, 64'(c - 1), 64'd32);
        check({tag, "_hilo"}, {HI, LO}, {exp_hi, exp_lo});
        tick();
        check({tag, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
        if (inj == 1) begin
            for (int i = 0; i < 40; i++) begin
                if (done) extra++;
                tick();
            end
            check({tag, "_no_second_done"}, 64'(extra), 64'd0);
            check({tag, "_hilo_kept"}, {HI, LO}, {exp_hi, exp_lo});
        end
    endtask

    initial begin
        int pulses;
        rst = 1'b1; start = 1'b0; AluOP = 4'd0; X = '0; Y = '0;
        mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;
        repeat (3) tick();
        check("reset_state", {30'd0, busy, done, HI}, 64'd0);
        check("reset_lo", {32'd0, LO}, 64'd0);
        rst = 1'b0;
        tick();

        launch(4'd3, 32'd7, 32'd6, 1'b0, '0);
        check("mul7x6_busy_after_e0", {63'd0, busy}, 64'd1);
        wait_done("mul7x6", 32'h0, 32'h2A, 0, 0);

        launch(4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, '0);
        wait_done("mulmax", 32'hFFFFFFFE, 32'h00000001, 0, 0);

        launch(4'd4, 32'd100, 32'd7, 1'b0, '0);
        wait_done("div100_7", 32'd2, 32'd14, 0, 0);

        launch(4'd4, 32'h00001234, 32'd0, 1'b0, '0);
        wait_done("div_by0", 32'h00001234, 32'hFFFFFFFF, 0, 0);

        launch(4'd3, 32'd3, 32'd5, 1'b0, '0);
        wait_done("mul3x5_stray", 32'd0, 32'd15, 1, 10);

        launch(4'd5, 32'd1, 32'd1, 1'b0, '0);
        check("badop_busy", {62'd0, busy, done}, 64'd0);
        repeat (3) tick();
        check("badop_busy_later", {62'd0, busy, done}, 64'd0);

        mtlo_we = 1'b1; wdata = 32'hDEADBEEF;
        tick();
        mtlo_we = 1'b0;
        check("mtlo_idle", {HI, LO}, {32'd0, 32'hDEADBEEF});

        mthi_we = 1'b1; wdata = 32'h11111111;
        tick();
        mthi_we = 1'b0;
        check("mthi_idle", {32'd0, HI}, 64'h11111111);

        launch(4'd4, 32'd50, 32'd8, 1'b0, '0);
        wait_done("div50_8_mthi", 32'd2, 32'd6, 2, 5);

        mthi_we = 1'b1; wdata = 32'h11111111;
        tick();
        mthi_we = 1'b0;
        launch(4'd3, 32'h00010000, 32'h00030000, 1'b1, 32'h22222222);
        check("start_wins_over_mthi", {32'd0, HI}, 64'h11111111);
        wait_done("mul_big", 32'd3, 32'd0, 0, 0);

        // DONE-cycle write overrides the fresh LO
        launch(4'd3, 32'd4, 32'd4, 1'b0, '0);
        begin
            int c = 1;
            while (!done && c < 100) begin
                if (c == 32) begin mtlo_we = 1'b1; wdata = 32'h0BADF00D; end
                tick();
                c++;
            end
        end
        check("done_cycle_seen", {63'd0, done}, 64'd1);
        check("done_result", {32'd0, LO}, 64'd16);
        tick();
        mtlo_we = 1'b0;
        check("done_write_override", {HI, LO}, {32'd0, 32'h0BADF00D});

        launch(4'd3, 32'd9, 32'd9, 1'b0, '0);
        for (int c = 1; c < 12; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midop_reset", {30'd0, busy, done, HI}, 64'd0);
        check("midop_reset_lo", {32'd0, LO}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) pulses++;
            tick();
        end
        check("midop_reset_quiet", 64'(pulses), 64'd0);

        launch(4'd3, 32'd2, 32'd3, 1'b0, '0);
        wait_done("mul2x3", 32'd0, 32'd6, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
